alu_decode_stage: RTL



---
 rtl/alu_decode_stage_if.sv | 34 +++
 rtl/alu_decode_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and the execute-stage ALU.
// master drives instructions and consumes decoded entries; slave is the stage.
interface alu_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_reg_write;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_reg_write, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_reg_write, out_illegal, out_pc
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I OP / OP-IMM / LUI decoder with a single registered slot toward execute
// and a saturating count of illegal entries handed downstream.
module alu_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRA  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SSLT = 4'd7,
        ALU_USLT = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    alu_op_e         w_f3_op;
    alu_op_e         w_alu_op;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_use_imm;
    logic            w_legal;
    logic            w_in_ready;
    logic            w_accept;

    logic            r_valid;
    alu_op_e         r_alu_op;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_imm;
    logic            r_use_imm;
    logic            r_reg_write;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;
    logic [CNT_W-1:0] r_cnt;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_funct3 = w_inst[14:12];
    assign w_funct7 = w_inst[31:25];

    always_comb begin
        w_f3_op = ALU_ADD;
        case (w_funct3)
            3'b000: w_f3_op = ALU_ADD;
            3'b001: w_f3_op = ALU_SLL;
            3'b010: w_f3_op = ALU_SSLT;
            3'b011: w_f3_op = ALU_USLT;
            3'b100: w_f3_op = ALU_XOR;
            3'b101: w_f3_op = ALU_SRL;
            3'b110: w_f3_op = ALU_OR;
            3'b111: w_f3_op = ALU_AND;
            default: w_f3_op = ALU_ADD;
        endcase
    end

    always_comb begin
        w_alu_op  = w_f3_op;
        w_rs1     = w_inst[19:15];
        w_rs2     = w_inst[24:20];
        w_rd      = w_inst[11:7];
        w_imm     = '0;
        w_use_imm = 1'b0;
        w_legal   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    w_legal = 1'b1;
                end else if (w_funct7 == F7_ALT) begin
                    if (w_funct3 == 3'b000) begin
                        w_legal  = 1'b1;
                        w_alu_op = ALU_SUB;
                    end else if (w_funct3 == 3'b101) begin
                        w_legal  = 1'b1;
                        w_alu_op = ALU_SRA;
                    end
                end
            end
            OPC_OPIMM: begin
                w_rs2     = '0;
                w_use_imm = 1'b1;
                w_imm     = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
                case (w_funct3)
                    3'b001: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_imm   = {{(XLEN-5){1'b0}}, w_inst[24:20]};
                    end
                    3'b101: begin
                        w_legal  = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                        w_imm    = {{(XLEN-5){1'b0}}, w_inst[24:20]};
                        w_alu_op = w_inst[30] ? ALU_SRA : ALU_SRL;
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_legal   = 1'b1;
                w_alu_op  = ALU_ADD;
                w_rs1     = '0;
                w_use_imm = 1'b1;
                w_imm     = XLEN'({w_inst[31:12], 12'b0});
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal entries still travel downstream, but with neutral operands.
        if (!w_legal) begin
            w_alu_op  = ALU_ADD;
            w_imm     = '0;
            w_use_imm = 1'b0;
        end
    end

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_pc        <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_alu_op    <= w_alu_op;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_use_imm   <= w_use_imm;
            r_reg_write <= w_legal;
            r_illegal   <= !w_legal;
            r_pc        <= bus.in_pc;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Counts the consuming handshake even when flush is asserted that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_valid && bus.out_ready && r_illegal && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.out_alu_op    = r_alu_op;
    assign bus.out_rs1       = r_rs1;
    assign bus.out_rs2       = r_rs2;
    assign bus.out_rd        = r_rd;
    assign bus.out_imm       = r_imm;
    assign bus.out_use_imm   = r_use_imm;
    assign bus.out_reg_write = r_reg_write;
    assign bus.out_illegal   = r_illegal;
    assign bus.out_pc        = r_pc;
    assign illegal_cnt       = r_cnt;
endmodule
